pred_update_queue: RTL
======================

Name: pred_update_queue

Overview:
- Sits between the commit stage and the branch predictor's update ports.
- Takes up to two resolved branches per cycle, in program order, from commit. Issues at most one BTB/RAS correction pulse per cycle.
- Buffers conditional-branch outcomes in a small FIFO and drains one orientation update per cycle.
- Never back-pressures commit. Predictor training is a hint, so outcomes that do not fit are dropped and counted.

Parameters:
- DEPTH, 4, orientation FIFO entries; power of two, at least 2.
- CNTW, 16, width of the drop counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- res_valid_0 / res_valid_1  in  1  commit slot holds a resolved branch; slot 0 is older
- res_pc_0 / res_pc_1  in  32  PC of the branch
- res_type_0 / res_type_1  in  3  branch type, BR_* encoding from the shared definitions header
- res_taken_0 / res_taken_1  in  1  resolved direction
- res_mistaken_0 / res_mistaken_1  in  1  front-end prediction was wrong (direction or target)
- res_target_0 / res_target_1  in  32  resolved taken-target
- update_orien_en  out  1  orientation update valid this cycle
- retire_pc  out  32  PC for the orientation update
- right_orien  out  1  resolved direction for the orientation update
- branch_mistaken  out  1  one-cycle BTB correction pulse
- wrong_pc  out  32  PC of the mispredicted branch
- right_target  out  32  corrected target
- ins_type_w  out  3  type of the mispredicted branch
- drop_cnt  out  CNTW  saturating count of dropped orientation updates
- q_count  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset. All of these are 0 in the cycle after the reset edge: wr_ptr, rd_ptr, q_count, drop_cnt, branch_mistaken, wrong_pc, right_target, ins_type_w, update_orien_en. Stored entry data need not be cleared. Reset asserted mid-operation discards all queued entries.
- Slot kill. If res_valid_0 and res_mistaken_0 are both high, slot 1 is ignored entirely in that cycle: no enqueue and no correction. Slot 0 is still processed normally.
- Effective slot 1: eff1 = res_valid_1 & ~(res_valid_0 & res_mistaken_0).
- Correction path. This path is registered, with 1-cycle latency and no queue.
  - Select slot 0 if res_valid_0 & res_mistaken_0.
  - Else select slot 1 if eff1 & res_mistaken_1.
  - On a selection, branch_mistaken=1 at the next edge, with wrong_pc, right_target and ins_type_w latched from the selected slot. Otherwise branch_mistaken=0 and the data outputs hold their previous values.
  - Exactly one pulse per qualifying cycle; back-to-back cycles give back-to-back pulses.
- Enqueue.
  - A slot is a candidate if it is valid/effective and its type == BR_COND. Candidates are handled in order: slot 0 first, then slot 1.
  - space = DEPTH - q_count, sampled at the start of the cycle. A same-cycle dequeue is not credited.
  - With 2 candidates: space>=2 enqueues both; space==1 enqueues slot 0 and drops slot 1; space==0 drops both.
  - Each entry stores {pc, taken}.
- Drop counter. drop_cnt increments by the number of drops in the cycle (0, 1 or 2) and saturates at all-ones; it never wraps.
- Dequeue.
  - update_orien_en = (q_count != 0), driven combinationally from registered state; retire_pc and right_orien come from the head entry.
  - The predictor always accepts, so when q_count != 0 the head pops at every edge.
  - Enqueue-to-output latency is 1 cycle when the queue is empty (entry written at edge N is visible after edge N). There is no bypass from inputs.
- Occupancy. q_count_next = q_count + enq_num - deq, with enq_num in 0..2 and deq in 0..1. Pointers wrap modulo DEPTH. Simultaneous enqueue and dequeue when full is legal: the pop happens and enqueues are limited by the pre-pop space.
- Non-conditional types (direct, call, ret, indirect, nop) never enqueue. They may still produce a correction.
- When update_orien_en=0, retire_pc and right_orien are don't-care.

Test Plan:
- Reset, then idle for 5 cycles -> all outputs 0, q_count=0, drop_cnt=0.
- Single cond branch: slot 0 valid, pc=0x1c000010, type BR_COND, taken=1, mistaken=0 -> next cycle update_orien_en=1, retire_pc=0x1c000010, right_orien=1; following cycle update_orien_en=0; branch_mistaken stays 0.
- Both slots mistaken: slot 0 pc=0x100, target=0x200, call type; slot 1 cond, mistaken -> one pulse with wrong_pc=0x100, right_target=0x200, ins_type_w=call; slot 1 neither enqueued nor corrected; q_count stays 0.
- Slot 0 cond, not mistaken; slot 1 indirect, pc=0x304, target=0x4000, mistaken -> correction pulse with wrong_pc=0x304, right_target=0x4000; slot 0 pc enqueued and drained next cycle.
- Overflow: DEPTH=4, two cond branches per cycle for 4 cycles -> queue fills, drops occur as predicted by the pre-pop space rule, drop_cnt equals total drops; drained PCs come out in program order with no loss among accepted entries.
- Saturation: force 2^CNTW+3 drops (use CNTW=4 in the bench) -> drop_cnt holds 0xF; reset mid-drain -> q_count=0 and update_orien_en=0 in the next cycle.

Source files
------------

// File: rtl/pred_update_queue.sv
// pred_update_queue: buffers resolved conditional-branch outcomes from commit
// (two slots per cycle) and drains one orientation update per cycle into the
// branch predictor. It also issues a registered one-cycle BTB/RAS correction
// pulse for the oldest mispredicted slot. Commit is never stalled. Outcomes
// that do not fit in the queue are dropped and counted with saturation.
module pred_update_queue #(
    parameter int DEPTH = 4,   // orientation FIFO entries, power of two, >= 2
    parameter int CNTW  = 16   // drop counter width
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     res_valid_0,
    input  logic                     res_valid_1,
    input  logic [31:0]              res_pc_0,
    input  logic [31:0]              res_pc_1,
    input  logic [2:0]               res_type_0,
    input  logic [2:0]               res_type_1,
    input  logic                     res_taken_0,
    input  logic                     res_taken_1,
    input  logic                     res_mistaken_0,
    input  logic                     res_mistaken_1,
    input  logic [31:0]              res_target_0,
    input  logic [31:0]              res_target_1,
    output logic                     update_orien_en,
    output logic [31:0]              retire_pc,
    output logic                     right_orien,
    output logic                     branch_mistaken,
    output logic [31:0]              wrong_pc,
    output logic [31:0]              right_target,
    output logic [2:0]               ins_type_w,
    output logic [CNTW-1:0]          drop_cnt,
    output logic [$clog2(DEPTH):0]   q_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = CNTW + 1;

    // Branch type encoding shared with the commit stage:
    // 0 nop, 1 cond, 2 direct, 3 call, 4 ret, 5 indirect.
    localparam logic [2:0] BR_COND = 3'd1;

    // Queue state
    logic [31:0]   pc_mem_q    [DEPTH];
    logic          taken_mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic [CNTW-1:0] drop_q, drop_d;

    // Correction state
    logic          mis_q;
    logic [31:0]   wrong_pc_q;
    logic [31:0]   right_target_q;
    logic [2:0]    ins_type_q;

    // A mispredicted slot 0 squashes slot 1: it is on the wrong path.
    logic kill1, eff1, sel0, sel1;
    logic cand0, cand1;
    assign kill1 = res_valid_0 & res_mistaken_0;
    assign eff1  = res_valid_1 & ~kill1;
    assign sel0  = kill1;
    assign sel1  = eff1 & res_mistaken_1;
    assign cand0 = res_valid_0 & (res_type_0 == BR_COND);
    assign cand1 = eff1 & (res_type_1 == BR_COND);

    logic [1:0]    cand_num, enq_num, drops;
    logic [CW-1:0] space;
    logic          deq;
    logic [31:0]   first_pc;
    logic          first_taken;
    logic [AW-1:0] wr_ptr_nx;
    logic [DW-1:0] drop_sum;

    // Enqueue/drop arbitration against the pre-pop free space, plus next-state.
    always_comb begin
        // NOTE: every always_comb output is given a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        cand_num    = 2'(cand0) + 2'(cand1);
        space       = CW'(DEPTH) - count_q;
        enq_num     = cand_num;
        if (space < CW'(cand_num)) begin
            enq_num = space[1:0];
        end
        drops       = cand_num - enq_num;
        deq         = (count_q != '0);
        first_pc    = cand0 ? res_pc_0    : res_pc_1;
        first_taken = cand0 ? res_taken_0 : res_taken_1;
        wr_ptr_nx   = wr_ptr_q + AW'(1);
        wr_ptr_d    = wr_ptr_q + AW'(enq_num);
        rd_ptr_d    = rd_ptr_q + AW'(deq);
        count_d     = count_q + CW'(enq_num) - CW'(deq);
        drop_sum    = {1'b0, drop_q} + DW'(drops);
        drop_d      = drop_sum[CNTW] ? '1 : drop_sum[CNTW-1:0];
    end

    // Queue pointers, occupancy and saturating drop counter.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
        end
    end

    // Entry storage: up to two writes per cycle, oldest candidate first.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is not reset; occupancy alone decides
        // which entries are meaningful, so clearing it would only cost area.
        if (enq_num != 2'd0) begin
            pc_mem_q[wr_ptr_q]    <= first_pc;
            taken_mem_q[wr_ptr_q] <= first_taken;
        end
        if (enq_num == 2'd2) begin
            pc_mem_q[wr_ptr_nx]    <= res_pc_1;
            taken_mem_q[wr_ptr_nx] <= res_taken_1;
        end
    end

    // Registered correction pulse; data holds its last value between pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            mis_q          <= 1'b0;
            wrong_pc_q     <= '0;
            right_target_q <= '0;
            ins_type_q     <= '0;
        end else begin
            mis_q <= sel0 | sel1;
            if (sel0) begin
                wrong_pc_q     <= res_pc_0;
                right_target_q <= res_target_0;
                ins_type_q     <= res_type_0;
            end else if (sel1) begin
                wrong_pc_q     <= res_pc_1;
                right_target_q <= res_target_1;
                ins_type_q     <= res_type_1;
            end
        end
    end

    assign update_orien_en = (count_q != '0);
    assign retire_pc       = pc_mem_q[rd_ptr_q];
    assign right_orien     = taken_mem_q[rd_ptr_q];
    assign branch_mistaken = mis_q;
    assign wrong_pc        = wrong_pc_q;
    assign right_target    = right_target_q;
    assign ins_type_w      = ins_type_q;
    assign drop_cnt        = drop_q;
    assign q_count         = count_q;

endmodule
